// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg: shared encodings for the JTAG master.
// Contents: command opcodes, the 16-state IEEE 1149.1 TAP enum, the
// sequencer state enum, and tap_next(), the TAP next-state function.
package jtag_master_pkg;

    typedef enum logic [1:0] {
        OP_RESET    = 2'd0,
        OP_SHIFT_IR = 2'd1,
        OP_SHIFT_DR = 2'd2,
        OP_NOP      = 2'd3
    } op_t;

    typedef enum logic [3:0] {
        TAP_RESET,
        TAP_IDLE,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_t;

    typedef enum logic [2:0] {
        IDLE,
        PRE_RESET,
        HEAD,
        SHIFT,
        TAIL,
        DONE
    } seq_t;

    localparam int RESET_BITS = 6;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TAP_RESET:    return tms ? TAP_RESET    : TAP_IDLE;
            TAP_IDLE:     return tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_DR:   return tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   return tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: return tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: return tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: return tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: return tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   return tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_IR:   return tms ? TAP_RESET    : TAP_CAP_IR;
            TAP_CAP_IR:   return tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: return tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: return tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: return tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: return tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            default:      return tms ? TAP_SEL_DR   : TAP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: tracks the TAP controller state of the scanned device.
// Ports: CLK/RST (sync, active-high); en strobes one TCK rise; tms is the
// TMS level seen on that rise; state is the current TAP state (tap_t code).
module jtag_tap_fsm
    import jtag_master_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       en,
    input  logic       tms,
    output logic [3:0] state
);

    always_ff @(posedge CLK) begin
        if (RST) state <= TAP_RESET;
        else if (en) state <= tap_next(tap_t'(state), tms);
    end

endmodule

// File: rtl/jtag_master.sv
// jtag_master: turns RESET / SHIFT_IR / SHIFT_DR commands into TCK/TMS/TDI
// sequences at CLK/2 and returns the TDO bits captured while shifting.
// Ports: CLK/RST (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_len/
// cmd_data command handshake; rsp_valid pulse with rsp_data capture;
// TCK/TMS/TDI to the chain, TDO from it.
module jtag_master
    import jtag_master_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LW      = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LW-1:0]      cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);

    seq_t               state, state_n, start, after;
    logic               ph, ph_n;
    logic [LW-1:0]      cnt, cnt_n, len_r;
    logic [1:0]         op_r;
    logic [MAX_LEN-1:0] sr, cap;
    logic               tap_sync;
    logic [3:0]         tap;
    logic               accept, active, rise, last, is_ir, tms_bit, tdi_bit, cap_en;

    assign cmd_ready = state == IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign active    = state inside {PRE_RESET, HEAD, SHIFT, TAIL};
    // ph=0: next edge drives the low phase of the current bit; ph=1: next edge raises TCK
    assign rise      = active && ph;

    jtag_tap_fsm u_tap (
        .CLK   (CLK),
        .RST   (RST),
        .en    (rise),
        .tms   (TMS),
        .state (tap)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            ph    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ph    <= ph_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ph_n    = ph;
        // zero-length shifts and reserved ops go straight to DONE with no TCK activity
        start   = cmd_op == OP_RESET ? PRE_RESET
                : (cmd_op == OP_SHIFT_IR || cmd_op == OP_SHIFT_DR) && cmd_len != '0
                  ? (tap_sync ? HEAD : PRE_RESET)
                : DONE;
        if (state == IDLE) begin
            if (accept) begin
                state_n = start;
                cnt_n   = '0;
                ph_n    = 1'b0;
            end
        end else if (state == DONE) begin
            state_n = IDLE;
        end else if (!ph) begin
            ph_n = 1'b1;
        end else begin
            ph_n    = 1'b0;
            cnt_n   = last ? '0 : cnt + LW'(1);
            state_n = last ? after : state;
        end
    end

    always_comb begin
        is_ir   = op_r == OP_SHIFT_IR;
        tms_bit = state == PRE_RESET ? cnt != LW'(RESET_BITS - 1)
                : state == HEAD      ? cnt == '0 || (is_ir && cnt == LW'(1))
                : state == SHIFT     ? cnt == len_r - LW'(1)
                : state == TAIL && cnt == '0;
        last    = state == PRE_RESET ? cnt == LW'(RESET_BITS - 1)
                : state == HEAD      ? cnt == (is_ir ? LW'(3) : LW'(2))
                : state == SHIFT     ? cnt == len_r - LW'(1)
                : state == TAIL && cnt == LW'(1);
        after   = state == PRE_RESET ? (op_r == OP_RESET ? DONE : HEAD)
                : state == HEAD      ? SHIFT
                : state == SHIFT     ? TAIL
                : DONE;
        tdi_bit = state == SHIFT && sr[0];
        // the tracker is in Shift-xR exactly on the rises of the shift bits
        cap_en  = rise && (tap == TAP_SHIFT_DR || tap == TAP_SHIFT_IR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            TCK       <= 1'b0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            tap_sync  <= 1'b0;
            op_r      <= '0;
            len_r     <= '0;
            sr        <= '0;
            cap       <= '0;
        end else begin
            rsp_valid <= state == DONE;
            if (state == DONE) rsp_data <= cap;
            TCK <= rise;
            // TMS/TDI only move on the low-phase edge and hold through the high phase
            TMS <= active ? (ph ? TMS : tms_bit) : 1'b0;
            TDI <= active ? (ph ? TDI : tdi_bit) : 1'b0;
            if (accept) begin
                op_r  <= cmd_op;
                len_r <= cmd_len;
                sr    <= cmd_data;
                cap   <= '0;
                if (start != DONE) tap_sync <= 1'b1;
            end
            if (rise && state == SHIFT) sr <= sr >> 1;
            if (cap_en) cap <= cap | ({{(MAX_LEN-1){1'b0}}, TDO} << cnt);
        end
    end

endmodule
